// File: rtl/fpu_pkg.sv
// Shared FP32 multiply-path definitions: exception codes, normaliser states, constants.
package fpu_pkg;

  localparam logic [2:0] EXC_NONE = 3'b000;
  localparam logic [2:0] EXC_ZERO = 3'b001;
  localparam logic [2:0] EXC_NAN  = 3'b011;
  localparam logic [2:0] EXC_INF  = 3'b100;

  typedef enum logic [2:0] {
    IDLE,
    NORM,
    ROUND,
    RENORM,
    DONE
  } norm_state_t;

  localparam logic [31:0] QNAN    = 32'h7FC0_0000;
  localparam int          EXP_MAX = 255;

endpackage

// File: rtl/mul_norm_round.sv
// FP32 multiply post-stage: normalise, round, range-check and pack the 48-bit product.
// Build option MUL_RNE_EN selects round-to-nearest-even; undefined truncates and never uses RENORM.
//
// state  | meaning
// IDLE   | waiting for Norm_valid, inputs captured on the accepting edge
// NORM   | exception bypass or 1-bit normalise, extract M/G/R/S
// ROUND  | apply rounding increment, pack unless the significand carries out
// RENORM | carry out of rounding: shift right, bump exponent, pack
// DONE   | Norm_ack high until Norm_valid drops
module mul_norm_round
  import fpu_pkg::*;
#(
  parameter int MANT_W = 48,
  parameter int EXP_W  = 10
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              Norm_valid,
  input  logic              Norm_sign,
  input  logic [EXP_W-1:0]  Norm_exp,
  input  logic [MANT_W-1:0] Norm_mant,
  input  logic [2:0]        Norm_exc_in,
  output logic [31:0]       Norm_dataout,
  output logic [2:0]        Norm_exc,
  output logic              Norm_ack
);

  norm_state_t       state_q, state_d;
  logic              sign_q, sign_d;
  logic [EXP_W-1:0]  exp_q, exp_d;
  logic [MANT_W-1:0] mant_q, mant_d;
  logic [2:0]        exc_in_q, exc_in_d;
  logic [23:0]       m_q, m_d;
  logic [2:0]        grs_q, grs_d;
  logic [31:0]       data_q, data_d;
  logic [2:0]        exc_q, exc_d;

`ifdef MUL_RNE_EN
  logic              inc;
  logic [24:0]       m25;
`else
  logic              unused_trunc;
  assign unused_trunc = ^{grs_q, m_q[23]};
`endif

  // Exponent is two's complement; negative or zero flushes, >=255 saturates to infinity.
  function automatic logic [34:0] pack_result(input logic sign, input logic [EXP_W-1:0] exp,
                                              input logic [22:0] frac);
    if (!exp[EXP_W-1] && exp >= EXP_W'(EXP_MAX)) return {EXC_INF, sign, 8'hFF, 23'h0};
    else if (exp[EXP_W-1] || exp == '0)          return {EXC_ZERO, sign, 31'h0};
    else                                         return {EXC_NONE, sign, exp[7:0], frac};
  endfunction

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      sign_q   <= 1'b0;
      exp_q    <= '0;
      mant_q   <= '0;
      exc_in_q <= '0;
      m_q      <= '0;
      grs_q    <= '0;
      data_q   <= '0;
      exc_q    <= EXC_NONE;
    end else begin
      state_q  <= state_d;
      sign_q   <= sign_d;
      exp_q    <= exp_d;
      mant_q   <= mant_d;
      exc_in_q <= exc_in_d;
      m_q      <= m_d;
      grs_q    <= grs_d;
      data_q   <= data_d;
      exc_q    <= exc_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    sign_d   = sign_q;
    exp_d    = exp_q;
    mant_d   = mant_q;
    exc_in_d = exc_in_q;
    m_d      = m_q;
    grs_d    = grs_q;
    data_d   = data_q;
    exc_d    = exc_q;
`ifdef MUL_RNE_EN
    inc      = 1'b0;
    m25      = '0;
`endif
    case (state_q)
      IDLE: begin
        if (Norm_valid) begin
          sign_d   = Norm_sign;
          exp_d    = Norm_exp;
          mant_d   = Norm_mant;
          exc_in_d = Norm_exc_in;
          state_d  = NORM;
        end
      end
      NORM: begin
        state_d = DONE;
        if (exc_in_q == EXC_NAN) begin
          data_d = QNAN;
          exc_d  = EXC_NAN;
        end else if (exc_in_q == EXC_INF) begin
          data_d = {sign_q, 8'hFF, 23'h0};
          exc_d  = EXC_INF;
        end else if (exc_in_q == EXC_ZERO || mant_q == '0) begin
          data_d = {sign_q, 31'h0};
          exc_d  = EXC_ZERO;
        end else begin
          state_d = ROUND;
          if (mant_q[MANT_W-1]) begin
            m_d   = mant_q[MANT_W-1 -: 24];
            grs_d = {mant_q[MANT_W-25], mant_q[MANT_W-26], |mant_q[MANT_W-27:0]};
            exp_d = exp_q + EXP_W'(1);
          end else begin
            m_d   = mant_q[MANT_W-2 -: 24];
            grs_d = {mant_q[MANT_W-26], mant_q[MANT_W-27], |mant_q[MANT_W-28:0]};
          end
        end
      end
      ROUND: begin
        state_d = DONE;
`ifdef MUL_RNE_EN
        inc = grs_q[2] & (grs_q[1] | grs_q[0] | m_q[0]);
        m25 = {1'b0, m_q} + 25'(inc);
        if (m25[24]) begin
          m_d     = m25[24:1];
          state_d = RENORM;
        end else begin
          {exc_d, data_d} = pack_result(sign_q, exp_q, m25[22:0]);
        end
`else
        {exc_d, data_d} = pack_result(sign_q, exp_q, m_q[22:0]);
`endif
      end
      RENORM: begin
        exp_d           = exp_q + EXP_W'(1);
        {exc_d, data_d} = pack_result(sign_q, exp_d, m_q[22:0]);
        state_d         = DONE;
      end
      DONE: begin
        if (!Norm_valid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    Norm_ack     = (state_q == DONE);
    Norm_dataout = data_q;
    Norm_exc     = exc_q;
  end

endmodule

// File: tb/tb_mul_norm_round.sv
// Directed vector bench for mul_norm_round, covering both MUL_RNE_EN builds.
module tb_mul_norm_round;
  import fpu_pkg::*;

  typedef struct {
    string       name;
    logic        sign;
    logic [9:0]  exp;
    logic [47:0] mant;
    logic [2:0]  exc_in;
    logic [31:0] want_data;
    logic [2:0]  want_exc;
    int          want_lat;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic        sign;
  logic [9:0]  exp_in;
  logic [47:0] mant;
  logic [2:0]  exc_in;
  logic [31:0] dataout;
  logic [2:0]  exc;
  logic        ack;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mul_norm_round #(.MANT_W(48), .EXP_W(10)) dut (
    .CLK         (clk),
    .RST         (rst),
    .Norm_valid  (valid),
    .Norm_sign   (sign),
    .Norm_exp    (exp_in),
    .Norm_mant   (mant),
    .Norm_exc_in (exc_in),
    .Norm_dataout(dataout),
    .Norm_exc    (exc),
    .Norm_ack    (ack)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, got, want);
    end
  endtask

  task automatic drive(input vec_t v);
    sign   = v.sign;
    exp_in = v.exp;
    mant   = v.mant;
    exc_in = v.exc_in;
  endtask

  // Capture edge counts as edge 1; returns edges until ack is seen at a negedge, 0 on timeout.
  task automatic wait_ack(output int lat);
    lat = 1;
    @(posedge clk);
    @(negedge clk);
    while (!ack && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    if (!ack) lat = 0;
  endtask

  task automatic do_op(input vec_t v);
    int lat;
    logic [31:0] first;
    @(negedge clk);
    drive(v);
    valid = 1'b1;
    wait_ack(lat);
    check({v.name, " latency"}, lat, v.want_lat);
    check({v.name, " data"}, dataout, v.want_data);
    check({v.name, " exc"}, {29'b0, exc}, {29'b0, v.want_exc});
    first = dataout;
    @(posedge clk);
    @(negedge clk);
    check({v.name, " ack held"}, {31'b0, ack}, 32'd1);
    check({v.name, " data stable"}, dataout, first);
    valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check({v.name, " ack release"}, {31'b0, ack}, 32'd0);
  endtask

  vec_t vecs[14];
  vec_t t1;

  initial begin
    int lat;
    t1 = '{"t1_pos", 1'b0, 10'd130, 48'h7900_0000_0000, EXC_NONE, 32'h4172_0000, EXC_NONE, 3};
    vecs[0]  = t1;
    vecs[1]  = '{"t2_neg", 1'b1, 10'd130, 48'h7900_0000_0000, EXC_NONE, 32'hC172_0000, EXC_NONE, 3};
`ifdef MUL_RNE_EN
    vecs[2]  = '{"t3_tie_carry", 1'b0, 10'd127, 48'h7FFF_FFC0_0000, EXC_NONE, 32'h4000_0000, EXC_NONE, 4};
    vecs[3]  = '{"round_up", 1'b0, 10'd127, 48'h4000_0060_0000, EXC_NONE, 32'h3F80_0001, EXC_NONE, 3};
`else
    vecs[2]  = '{"t3_tie_trunc", 1'b0, 10'd127, 48'h7FFF_FFC0_0000, EXC_NONE, 32'h3FFF_FFFF, EXC_NONE, 3};
    vecs[3]  = '{"trunc_grs", 1'b0, 10'd127, 48'h4000_0060_0000, EXC_NONE, 32'h3F80_0000, EXC_NONE, 3};
`endif
    vecs[4]  = '{"tie_even", 1'b0, 10'd127, 48'h4000_0040_0000, EXC_NONE, 32'h3F80_0000, EXC_NONE, 3};
    vecs[5]  = '{"t4_ovf", 1'b0, 10'd254, 48'h8000_0000_0000, EXC_NONE, 32'h7F80_0000, EXC_INF, 3};
    vecs[6]  = '{"t4_unf", 1'b0, 10'd0, 48'h4000_0000_0000, EXC_NONE, 32'h0000_0000, EXC_ZERO, 3};
    vecs[7]  = '{"neg_exp", 1'b1, 10'h3FB, 48'h8000_0000_0000, EXC_NONE, 32'h8000_0000, EXC_ZERO, 3};
    vecs[8]  = '{"max_norm", 1'b0, 10'd253, 48'h8000_0000_0000, EXC_NONE, 32'h7F00_0000, EXC_NONE, 3};
    vecs[9]  = '{"min_norm", 1'b0, 10'd1, 48'h4000_0000_0000, EXC_NONE, 32'h0080_0000, EXC_NONE, 3};
    vecs[10] = '{"t5_nan", 1'b1, 10'd5, 48'h1234_5678_9ABC, EXC_NAN, 32'h7FC0_0000, EXC_NAN, 2};
    vecs[11] = '{"t5_inf", 1'b1, 10'd130, 48'h7900_0000_0000, EXC_INF, 32'hFF80_0000, EXC_INF, 2};
    vecs[12] = '{"zero_in", 1'b1, 10'd130, 48'h7900_0000_0000, EXC_ZERO, 32'h8000_0000, EXC_ZERO, 2};
    vecs[13] = '{"zero_mant", 1'b0, 10'd100, 48'h0, EXC_NONE, 32'h0000_0000, EXC_ZERO, 2};

    rst = 1'b1; valid = 1'b0; sign = 1'b0; exp_in = '0; mant = '0; exc_in = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("reset ack", {31'b0, ack}, 32'd0);
    check("reset data", dataout, 32'h0);
    check("reset exc", {29'b0, exc}, 32'd0);

    for (int i = 0; i < 14; i++) do_op(vecs[i]);

    // Leave a nonzero result behind so the reset check below is meaningful.
    do_op(t1);

    // Reset while in ROUND: capture, NORM edge, then assert RST.
    @(negedge clk);
    drive(t1);
    valid = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    valid = 1'b0;
    check("rst_mid ack", {31'b0, ack}, 32'd0);
    check("rst_mid data", dataout, 32'h0);
    check("rst_mid exc", {29'b0, exc}, 32'd0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("rst_mid idle", {31'b0, ack}, 32'd0);
    do_op(t1);

    // Inputs changed after capture must not affect the result.
    @(negedge clk);
    drive(t1);
    valid = 1'b1;
    @(posedge clk);
    #1;
    sign = 1'b1; exp_in = 10'd3; mant = 48'hFFFF_FFFF_FFFF; exc_in = EXC_NAN;
    @(negedge clk);
    lat = 1;
    while (!ack && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check("ignore latency", lat, 3);
    check("ignore data", dataout, 32'h4172_0000);
    valid = 1'b0;
    @(posedge clk);
    @(negedge clk);

    // Valid dropped right after capture: operation completes, DONE for one cycle only.
    drive(vecs[1]);
    valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid = 1'b0;
    lat = 1;
    while (!ack && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check("viol latency", lat, 3);
    check("viol data", dataout, 32'hC172_0000);
    @(posedge clk);
    @(negedge clk);
    check("viol one cycle", {31'b0, ack}, 32'd0);
    check("viol data kept", dataout, 32'hC172_0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
